// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory path.
// Contents: access-size encodings, the controller state enum and the
// byte-lane mask helper used by the lane aligner.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_WAIT = 2'd1,
    DM_RESP = 2'd2
  } dm_state_e;

  // lane is the lowest byte lane touched by the access.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << lane;
      SZ_HALF: m = 4'b0011 << lane;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for the data memory.
// Ports:
//   size, addr_lo   access size and low address bits of the request
//   load_signed     sign-extend sub-word loads when set
//   wdata           right-justified store data
//   rword           word read from the array
//   byte_en         byte lanes written by a store
//   wword           store data shifted onto its lanes
//   rdata           extracted and extended load value
module dmem_lane_align
  import mips_mem_pkg::*;
#(
  parameter int BIG_ENDIAN = 0
) (
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        load_signed,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wword,
  output logic [31:0] rdata
);

  logic [1:0]  lane;
  logic [4:0]  shamt;
  logic [31:0] rshift;

  // On a big-endian image byte offset 0 sits in the most significant lane,
  // so a halfword at offset 0 occupies lanes 3:2.
  always_comb begin
    lane = 2'd0;
    case (size)
      SZ_BYTE: lane = (BIG_ENDIAN != 0) ? (2'd3 - addr_lo) : addr_lo;
      SZ_HALF: lane = (BIG_ENDIAN != 0) ? {~addr_lo[1], 1'b0} : {addr_lo[1], 1'b0};
      default: lane = 2'd0;
    endcase
  end

  assign shamt   = {lane, 3'b000};
  assign byte_en = lane_mask(size, lane);
  assign wword   = wdata << shamt;
  assign rshift  = rword >> shamt;

  always_comb begin
    rdata = rword;
    case (size)
      SZ_BYTE: rdata = {{24{load_signed & rshift[7]}}, rshift[7:0]};
      SZ_HALF: rdata = {{16{load_signed & rshift[15]}}, rshift[15:0]};
      default: rdata = rword;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: one load/store at a time over valid/ready, with a
// programmable number of wait states and one response strobe per request.
// Ports:
//   clk, reset                    clock; asynchronous active-high reset
//   req_valid/req_ready           request handshake
//   req_write, req_size,
//   req_signed, req_addr,
//   req_wdata                     request fields, captured at acceptance
//   resp_valid                    single-cycle response strobe
//   resp_rdata, resp_err          extended load data / error flag
//   busy                          controller not idle
//
// state   | meaning
// DM_IDLE | ready for a request
// DM_WAIT | counting wait states
// DM_RESP | response strobe; store commit and load sample happened on entry
module dmem_ctrl
  import mips_mem_pkg::*;
#(
  parameter int          DEPTH       = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0040_0000,
  parameter int          WAIT_STATES = 0,
  parameter int          BIG_ENDIAN  = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAST_WAIT = 4'(WAIT_STATES - 1);

  dm_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, signed_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept, enter_resp, do_write;
  logic        cur_wr, cur_signed;
  logic [1:0]  cur_size;
  logic [31:0] cur_addr, cur_wdata;
  logic [32:0] offset;
  logic        err_size, err_align, err_range, req_err;
  logic [AW-1:0] mem_idx;
  logic [3:0]  byte_en;
  logic [31:0] wword, rword, load_data;

  logic [31:0] mem [DEPTH];

  assign accept = req_valid && (state_q == DM_IDLE);

  // With zero wait states the accepting edge is also the commit edge, so the
  // live request fields are used while idle and the captured copy afterwards.
  assign cur_wr     = (state_q == DM_IDLE) ? req_write  : wr_q;
  assign cur_size   = (state_q == DM_IDLE) ? req_size   : size_q;
  assign cur_signed = (state_q == DM_IDLE) ? req_signed : signed_q;
  assign cur_addr   = (state_q == DM_IDLE) ? req_addr   : addr_q;
  assign cur_wdata  = (state_q == DM_IDLE) ? req_wdata  : wdata_q;

  // 33-bit subtract: an address below the base borrows into bit 32 instead
  // of wrapping to a large in-range-looking index. BASE_ADDR is word aligned,
  // so offset[1:0] equals the address low bits.
  assign offset    = {1'b0, cur_addr} - {1'b0, BASE_ADDR};
  assign err_size  = (cur_size == 2'd3);
  assign err_align = ((cur_size == SZ_HALF) && offset[0]) ||
                     ((cur_size == SZ_WORD) && (offset[1:0] != 2'b00));
  assign err_range = offset[32] || (offset[31:2] >= 30'(DEPTH));
  assign req_err   = err_size || err_align || err_range;
  assign mem_idx   = offset[AW+1:2];

  dmem_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
    .size        (cur_size),
    .addr_lo     (offset[1:0]),
    .load_signed (cur_signed),
    .wdata       (cur_wdata),
    .rword       (rword),
    .byte_en     (byte_en),
    .wword       (wword),
    .rdata       (load_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      DM_IDLE: begin
        if (req_valid) begin
          state_d = (WAIT_STATES == 0) ? DM_RESP : DM_WAIT;
          cnt_d   = 4'd0;
        end
      end
      DM_WAIT: begin
        if (cnt_q == LAST_WAIT) begin
          state_d = DM_RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DM_RESP: state_d = DM_IDLE;
      default: state_d = DM_IDLE;
    endcase
  end

  // RESP always exits to IDLE, so a next state of RESP means we are entering it.
  assign enter_resp = (state_d == DM_RESP);
  assign do_write   = enter_resp && cur_wr && !req_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= DM_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (enter_resp) begin
        err_q   <= req_err;
        rdata_q <= (req_err || cur_wr) ? 32'd0 : load_data;
      end else begin
        err_q   <= 1'b0;
        rdata_q <= 32'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q     <= req_write;
      size_q   <= req_size;
      signed_q <= req_signed;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
    end
  end

  // Array contents survive reset.
  assign rword = mem[mem_idx];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (do_write && byte_en[b]) mem[mem_idx][8*b +: 8] <= wword[8*b +: 8];
    end
  end

  assign req_ready  = (state_q == DM_IDLE);
  assign busy       = (state_q != DM_IDLE);
  assign resp_valid = (state_q == DM_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
